// File: rtl/generador_secuencia_if.sv
// Pattern load channel of the serial sequence generator (valid/ready).
interface generador_secuencia_if #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned REPS_W = 4
) ();
   logic [WIDTH-1:0]  patron;
   logic [REPS_W-1:0] repeticiones;
   logic              patron_valid;
   logic              patron_ready;

   modport master (output patron, output repeticiones, output patron_valid, input patron_ready);
   modport slave  (input patron, input repeticiones, input patron_valid, output patron_ready);
endinterface

// File: rtl/generador_secuencia.sv
// Serial bit-stream generator: loads a pattern over a valid/ready channel and
// shifts it out MSB first, optionally repeated with an idle gap between copies.
// Optional feature: define PARIDAD_EN to append an even-parity bit to every
// repetition (WIDTH+1 valid cycles per repetition instead of WIDTH).
module generador_secuencia #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned REPS_W     = 4,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   generador_secuencia_if.slave  bus,
   input  logic                  abortar,
   output logic                  x,
   output logic                  x_valid,
   output logic                  ocupado,
   output logic                  fin
);

   localparam int unsigned CNT_W    = $clog2(WIDTH);
   localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_FIN} state_t;

   state_t            state_q;
   logic [WIDTH-1:0]  hold_q;
   logic [WIDTH-1:0]  shift_q;
   logic [CNT_W-1:0]  bit_cnt_q;
   logic [REPS_W-1:0] rep_cnt_q;
   logic [GAP_W-1:0]  gap_cnt_q;
   logic              x_q;
   logic              x_valid_q;
   logic              ready_q;
   logic              ocupado_q;
   logic              fin_q;
`ifdef PARIDAD_EN
   logic              par_q;   // parity bit of the current repetition is on x
`endif

   // Whole controller: state, datapath registers and registered outputs.
   // bit_cnt_q counts the data bits still to come after the one currently on x.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         hold_q    <= '0;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         rep_cnt_q <= '0;
         gap_cnt_q <= '0;
         x_q       <= 1'b0;
         x_valid_q <= 1'b0;
         ready_q   <= 1'b1;
         ocupado_q <= 1'b0;
         fin_q     <= 1'b0;
`ifdef PARIDAD_EN
         par_q     <= 1'b0;
`endif
      end else begin
         fin_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // Abort in the handshake cycle wins: the pattern is dropped.
               if (bus.patron_valid && ready_q && !abortar) begin
                  hold_q    <= bus.patron;
                  shift_q   <= {bus.patron[WIDTH-2:0], 1'b0};
                  x_q       <= bus.patron[WIDTH-1];
                  x_valid_q <= 1'b1;
                  bit_cnt_q <= CNT_W'(WIDTH - 1);
                  rep_cnt_q <= (bus.repeticiones == '0) ? REPS_W'(1) : bus.repeticiones;
                  ready_q   <= 1'b0;
                  ocupado_q <= 1'b1;
                  state_q   <= S_SHIFT;
`ifdef PARIDAD_EN
                  par_q     <= 1'b0;
`endif
               end
            end

            S_SHIFT: begin
               if (abortar) begin
                  x_q       <= 1'b0;
                  x_valid_q <= 1'b0;
                  ready_q   <= 1'b1;
                  ocupado_q <= 1'b0;
                  state_q   <= S_IDLE;
               end else if (bit_cnt_q != '0) begin
                  x_q       <= shift_q[WIDTH-1];
                  shift_q   <= {shift_q[WIDTH-2:0], 1'b0};
                  bit_cnt_q <= bit_cnt_q - CNT_W'(1);
`ifdef PARIDAD_EN
               end else if (!par_q) begin
                  x_q   <= ^hold_q;
                  par_q <= 1'b1;
`endif
               end else begin
`ifdef PARIDAD_EN
                  par_q <= 1'b0;
`endif
                  if (rep_cnt_q == REPS_W'(1)) begin
                     x_q       <= 1'b0;
                     x_valid_q <= 1'b0;
                     fin_q     <= 1'b1;
                     state_q   <= S_FIN;
                  end else begin
                     rep_cnt_q <= rep_cnt_q - REPS_W'(1);
                     if (GAP_CYCLES > 0) begin
                        x_q       <= 1'b0;
                        x_valid_q <= 1'b0;
                        gap_cnt_q <= GAP_W'(GAP_LOAD);
                        state_q   <= S_GAP;
                     end else begin
                        // Back-to-back: next copy starts without a bubble.
                        x_q       <= hold_q[WIDTH-1];
                        shift_q   <= {hold_q[WIDTH-2:0], 1'b0};
                        bit_cnt_q <= CNT_W'(WIDTH - 1);
                     end
                  end
               end
            end

            S_GAP: begin
               if (abortar) begin
                  ready_q   <= 1'b1;
                  ocupado_q <= 1'b0;
                  state_q   <= S_IDLE;
               end else if (gap_cnt_q == '0) begin
                  x_q       <= hold_q[WIDTH-1];
                  x_valid_q <= 1'b1;
                  shift_q   <= {hold_q[WIDTH-2:0], 1'b0};
                  bit_cnt_q <= CNT_W'(WIDTH - 1);
                  state_q   <= S_SHIFT;
               end else begin
                  gap_cnt_q <= gap_cnt_q - GAP_W'(1);
               end
            end

            S_FIN: begin
               // Abort here has the same effect as the normal return.
               ready_q   <= 1'b1;
               ocupado_q <= 1'b0;
               state_q   <= S_IDLE;
            end

            default: begin
               x_q       <= 1'b0;
               x_valid_q <= 1'b0;
               ready_q   <= 1'b1;
               ocupado_q <= 1'b0;
               state_q   <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.patron_ready = ready_q;
   assign x                = x_q;
   assign x_valid          = x_valid_q;
   assign ocupado          = ocupado_q;
   assign fin              = fin_q;

endmodule

// File: tb/tb_generador_secuencia.sv
// Self-checking bench for generador_secuencia: two instances (gap of 2 and
// back-to-back) checked cycle by cycle against a per-cycle expectation list
// built from the transmission rules.
module tb_generador_secuencia;

   localparam int unsigned WIDTH  = 8;
   localparam int unsigned REPS_W = 4;
   localparam int unsigned GAP_A  = 2;
   localparam int unsigned GAP_B  = 0;
`ifdef PARIDAD_EN
   localparam int unsigned BPR = WIDTH + 1;
`else
   localparam int unsigned BPR = WIDTH;
`endif

   typedef struct packed {
      logic v;
      logic x;
      logic fin;
      logic busy;
      logic rdy;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [WIDTH-1:0]  patron_r = '0;
   logic [REPS_W-1:0] reps_r = '0;
   logic valid_a = 1'b0;
   logic valid_b = 1'b0;
   logic abortar = 1'b0;
   logic xa, xva, occa, fina, xb, xvb, occb, finb;
   int   sel = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   obs_t exp_q[$];
   obs_t obs_q[$];
   obs_t cur;

   always #5 clk = ~clk;

   generador_secuencia_if #(.WIDTH(WIDTH), .REPS_W(REPS_W)) if_a ();
   generador_secuencia_if #(.WIDTH(WIDTH), .REPS_W(REPS_W)) if_b ();

   assign if_a.patron       = patron_r;
   assign if_a.repeticiones = reps_r;
   assign if_a.patron_valid = valid_a;
   assign if_b.patron       = patron_r;
   assign if_b.repeticiones = reps_r;
   assign if_b.patron_valid = valid_b;

   generador_secuencia #(.WIDTH(WIDTH), .REPS_W(REPS_W), .GAP_CYCLES(GAP_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(if_a), .abortar(abortar),
      .x(xa), .x_valid(xva), .ocupado(occa), .fin(fina));

   generador_secuencia #(.WIDTH(WIDTH), .REPS_W(REPS_W), .GAP_CYCLES(GAP_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(if_b), .abortar(abortar),
      .x(xb), .x_valid(xvb), .ocupado(occb), .fin(finb));

   always_comb begin
      if (sel == 0) cur = '{v: xva, x: xa, fin: fina, busy: occa, rdy: if_a.patron_ready};
      else          cur = '{v: xvb, x: xb, fin: finb, busy: occb, rdy: if_b.patron_ready};
   end

   // Expected per-cycle trace from cycle 1 after the handshake up to the first idle cycle.
   task automatic build_expected(input logic [WIDTH-1:0] pat, input int reps, input int gap,
                                 input int abort_at);
      int n;
      n = (reps == 0) ? 1 : reps;
      exp_q.delete();
      for (int r = 0; r < n; r++) begin
         for (int b = WIDTH - 1; b >= 0; b--)
            exp_q.push_back('{v: 1'b1, x: pat[b], fin: 1'b0, busy: 1'b1, rdy: 1'b0});
`ifdef PARIDAD_EN
         exp_q.push_back('{v: 1'b1, x: ^pat, fin: 1'b0, busy: 1'b1, rdy: 1'b0});
`endif
         if (r != n - 1)
            for (int g = 0; g < gap; g++)
               exp_q.push_back('{v: 1'b0, x: 1'b0, fin: 1'b0, busy: 1'b1, rdy: 1'b0});
      end
      exp_q.push_back('{v: 1'b0, x: 1'b0, fin: 1'b1, busy: 1'b1, rdy: 1'b0});
      exp_q.push_back('{v: 1'b0, x: 1'b0, fin: 1'b0, busy: 1'b0, rdy: 1'b1});
      if (abort_at >= 0 && abort_at < exp_q.size() - 1) begin
         while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
         exp_q.push_back('{v: 1'b0, x: 1'b0, fin: 1'b0, busy: 1'b0, rdy: 1'b1});
      end
   endtask

   // Handshake one pattern, then record one observation per expected cycle.
   task automatic run_transfer(input int s, input logic [WIDTH-1:0] pat, input int reps,
                               input int abort_at, input bit noise);
      sel = s;
      build_expected(pat, reps, (s == 0) ? GAP_A : GAP_B, abort_at);
      patron_r = pat;
      reps_r   = REPS_W'(reps);
      if (s == 0) valid_a = 1'b1; else valid_b = 1'b1;
      @(posedge clk); #1;
      valid_a = 1'b0;
      valid_b = 1'b0;
      obs_q.delete();
      for (int i = 0; i < exp_q.size(); i++) begin
         obs_q.push_back(cur);
         if (i == abort_at) abortar = 1'b1;
         else abortar = 1'b0;
         if (noise && i < exp_q.size() - 1) begin
            patron_r = WIDTH'($urandom);
            reps_r   = REPS_W'($urandom);
            if (s == 0) valid_a = 1'($urandom); else valid_b = 1'($urandom);
         end else begin
            valid_a = 1'b0;
            valid_b = 1'b0;
         end
         @(posedge clk); #1;
      end
      abortar = 1'b0;
      valid_a = 1'b0;
      valid_b = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({xva, xa, fina, occa, if_a.patron_ready} !== 5'b00001) begin
         n_fail++;
         $display("FAIL reset_a: got v/x/fin/busy/rdy=%b expected 00001",
                  {xva, xa, fina, occa, if_a.patron_ready});
      end
      n_tests++;
      if ({xvb, xb, finb, occb, if_b.patron_ready} !== 5'b00001) begin
         n_fail++;
         $display("FAIL reset_b: got v/x/fin/busy/rdy=%b expected 00001",
                  {xvb, xb, finb, occb, if_b.patron_ready});
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [WIDTH-1:0] pats [4] = '{8'hB2, 8'hA5, 8'h07, 8'h3C};
      int reps [4] = '{1, 3, 0, 2};
      for (int t = 0; t < 4; t++) begin
         run_transfer(0, pats[t], reps[t], -1, 1'b0);
         for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
               n_fail++;
               $display("FAIL basic pat=%h reps=%0d cyc %0d: got v/x/fin/busy/rdy=%b expected %b",
                        pats[t], reps[t], i + 1, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int t = 0; t < 6; t++) begin
         logic [WIDTH-1:0] p;
         int r;
         p = (t == 0) ? 8'hA5 : WIDTH'($urandom);
         r = (t == 0) ? 2 : int'($urandom_range(0, 4));
         run_transfer(1, p, r, -1, 1'b0);
         for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
               n_fail++;
               $display("FAIL back_to_back pat=%h reps=%0d cyc %0d: got %b expected %b",
                        p, r, i + 1, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_random_busy();
      for (int t = 0; t < 24; t++) begin
         logic [WIDTH-1:0] p;
         int r, s;
         p = WIDTH'($urandom);
         r = int'($urandom_range(0, 3));
         s = int'($urandom_range(0, 1));
         run_transfer(s, p, r, -1, 1'b1);
         for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
               n_fail++;
               $display("FAIL random_busy dut=%0d pat=%h reps=%0d cyc %0d: got %b expected %b",
                        s, p, r, i + 1, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_abort();
      for (int t = 0; t < 10; t++) begin
         logic [WIDTH-1:0] p;
         int r, s, a;
         p = WIDTH'($urandom);
         r = int'($urandom_range(1, 3));
         s = int'($urandom_range(0, 1));
         a = (t == 0) ? 3 : int'($urandom_range(0, r * BPR));
         run_transfer(s, p, r, a, 1'b1);
         for (int i = 0; i < exp_q.size(); i++) begin
            n_tests++;
            if (obs_q[i] !== exp_q[i]) begin
               n_fail++;
               $display("FAIL abort dut=%0d at=%0d cyc %0d: got %b expected %b",
                        s, a, i + 1, obs_q[i], exp_q[i]);
            end
         end
         // No late fin and still idle after the abort.
         repeat (2) begin
            n_tests++;
            if (cur !== obs_t'(5'b00001)) begin
               n_fail++;
               $display("FAIL abort_after dut=%0d: got %b expected 00001", s, cur);
            end
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_abort_handshake();
      sel = 0;
      patron_r = 8'hFF;
      reps_r   = 4'd1;
      valid_a  = 1'b1;
      abortar  = 1'b1;
      @(posedge clk); #1;
      valid_a = 1'b0;
      abortar = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_tests++;
         if (cur !== obs_t'(5'b00001)) begin
            n_fail++;
            $display("FAIL abort_handshake cyc %0d: got %b expected 00001", i + 1, cur);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_async_reset();
      sel = 0;
      patron_r = 8'hA5;
      reps_r   = 4'd3;
      valid_a  = 1'b1;
      @(posedge clk); #1;
      valid_a = 1'b0;
      repeat (BPR) @(posedge clk);
      #1;
      n_tests++;
      if (cur !== obs_t'(5'b00010)) begin
         n_fail++;
         $display("FAIL async_reset_in_gap: got %b expected 00010", cur);
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if (cur !== obs_t'(5'b00001)) begin
         n_fail++;
         $display("FAIL async_reset_immediate: got %b expected 00001", cur);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         n_tests++;
         if (cur !== obs_t'(5'b00001)) begin
            n_fail++;
            $display("FAIL async_reset_after cyc %0d: got %b expected 00001", i + 1, cur);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_random_busy();
      test_abort();
      test_abort_handshake();
      test_async_reset();
      test_basic();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
